// File: rtl/riscv_pkg.sv
// riscv_pkg: shared data-memory types and sizes for the core, loader and arbiter.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int DMEM_SIZE = 1024;

  // Access width and sign handling requested on the data-memory port.
  typedef enum logic [2:0] {
    MEM_BYTE   = 3'd0,
    MEM_HALF   = 3'd1,
    MEM_WORD   = 3'd2,
    MEM_BYTE_U = 3'd4,
    MEM_HALF_U = 3'd5
  } mem_op_e;

  // Requester index on the data-memory arbiter.
  typedef enum logic {
    ARB_CORE = 1'b0,
    ARB_DMA  = 1'b1
  } arb_idx_e;

  // Number of bytes touched by an access; unknown encodings count as a word.
  function automatic logic [2:0] op_size(input mem_op_e op);
    case (op)
      MEM_BYTE, MEM_BYTE_U: return 3'd1;
      MEM_HALF, MEM_HALF_U: return 3'd2;
      MEM_WORD:             return 3'd4;
      default:              return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// dmem_arb_if: requester handshake, response and data-memory port bundle.
// slave = arbiter side, master = requesters and memory side.
interface dmem_arb_if;
  import riscv_pkg::*;

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][XLEN-1:0]  req_addr;
  logic [1:0][XLEN-1:0]  req_wdata;
  logic [1:0]            req_we;
  mem_op_e [1:0]         req_op;
  logic [1:0]            rsp_valid;
  logic [1:0][XLEN-1:0]  rsp_rdata;
  logic [1:0]            rsp_err;
  logic [XLEN-1:0]       m_addr;
  logic [XLEN-1:0]       m_wdata;
  logic                  m_wr_en;
  logic                  m_rd_en;
  mem_op_e               m_op;
  logic [XLEN-1:0]       m_rdata;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_we, req_op, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           m_addr, m_wdata, m_wr_en, m_rd_en, m_op
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_we, req_op, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           m_addr, m_wdata, m_wr_en, m_rd_en, m_op
  );

endinterface

// File: rtl/dmem_align_chk.sv
// dmem_align_chk: flags misaligned, out-of-range or illegal-store accesses.
module dmem_align_chk import riscv_pkg::*; (
  input  logic [XLEN-1:0] addr,
  input  mem_op_e         op,
  input  logic            we,
  output logic            fault
);

  // One extra bit so addr + size cannot wrap past the top of the address space.
  localparam logic [XLEN:0] DMEM_LIMIT = (XLEN+1)'(DMEM_SIZE);

  logic [XLEN:0] end_addr;

  // Decode alignment, store legality and range violations for this access.
  always_comb begin
    fault    = 1'b0;
    end_addr = {1'b0, addr} + {{(XLEN-2){1'b0}}, op_size(op)};
    case (op)
      MEM_BYTE:   fault = 1'b0;
      MEM_BYTE_U: fault = we;
      MEM_HALF:   fault = addr[0];
      MEM_HALF_U: fault = addr[0] | we;
      MEM_WORD:   fault = (addr[1:0] != 2'b00);
      default:    fault = 1'b1;
    endcase
    if (end_addr > DMEM_LIMIT) begin
      fault = 1'b1;
    end else begin
      fault = fault;
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// dmem_arb: arbitrates the core MEM stage and the DMA/loader onto one
// data-memory port with a fixed one-cycle response.
// Build option DMEM_ARB_RR_EN: round-robin on contention; otherwise the core
// has priority and a starvation counter force-grants the DMA after MAX_WAIT.
module dmem_arb import riscv_pkg::*; #(
  parameter int MAX_WAIT = 8
) (
  input logic       clk,
  input logic       reset,
  dmem_arb_if.slave bus
);

  logic [1:0]           grant;
  arb_idx_e             sel;
  logic [XLEN-1:0]      sel_addr;
  logic [XLEN-1:0]      sel_wdata;
  logic                 sel_we;
  mem_op_e              sel_op;
  logic                 fault;
  logic                 good_load;
  logic [1:0]           rsp_valid_r;
  logic [1:0]           rsp_err_r;
  logic [1:0][XLEN-1:0] rsp_rdata_r;

`ifdef DMEM_ARB_RR_EN
  arb_idx_e last_grant_r;
`else
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  logic [7:0] wait_cnt_r;
`endif

  // Pick at most one valid requester; nothing is granted while in reset.
  always_comb begin
    grant = 2'b00;
    if (reset) begin
      grant = 2'b00;
    end else if (bus.req_valid == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
      if (last_grant_r == ARB_CORE) grant = 2'b10;
      else                          grant = 2'b01;
`else
      if (wait_cnt_r == MAX_WAIT_C) grant = 2'b10;
      else                          grant = 2'b01;
`endif
    end else if (bus.req_valid[0]) begin
      grant = 2'b01;
    end else if (bus.req_valid[1]) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
  end

  assign sel           = grant[1] ? ARB_DMA : ARB_CORE;
  assign sel_addr      = bus.req_addr[sel];
  assign sel_wdata     = bus.req_wdata[sel];
  assign sel_we        = bus.req_we[sel];
  assign sel_op        = bus.req_op[sel];
  assign good_load     = !sel_we && !fault;
  assign bus.req_ready = grant;

  dmem_align_chk u_align_chk (
    .addr  (sel_addr),
    .op    (sel_op),
    .we    (sel_we),
    .fault (fault)
  );

  // Present the accepted request to memory; enables only for legal accesses.
  always_comb begin
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_op    = MEM_BYTE;
    bus.m_rd_en = 1'b0;
    bus.m_wr_en = 1'b0;
    if (grant != 2'b00) begin
      bus.m_addr  = sel_addr;
      bus.m_wdata = sel_wdata;
      bus.m_op    = sel_op;
      bus.m_rd_en = !sel_we && !fault;
      bus.m_wr_en = sel_we && !fault;
    end else begin
      bus.m_rd_en = 1'b0;
    end
  end

  // One-cycle response pipeline; read data holds between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r <= 2'b00;
      rsp_err_r   <= 2'b00;
      rsp_rdata_r <= '0;
    end else begin
      rsp_valid_r <= grant;
      rsp_err_r   <= grant & {2{fault}};
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) rsp_rdata_r[i] <= good_load ? bus.m_rdata : '0;
        else          rsp_rdata_r[i] <= rsp_rdata_r[i];
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_rdata = rsp_rdata_r;

`ifdef DMEM_ARB_RR_EN
  // Remember the last winner so contention alternates between requesters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              last_grant_r <= ARB_CORE;
    else if (grant != 2'b00) last_grant_r <= sel;
    else                    last_grant_r <= last_grant_r;
  end
`else
  // Count consecutive DMA denials, saturating where the DMA gets forced in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                wait_cnt_r <= 8'd0;
    else if (!bus.req_valid[1] || grant[1])   wait_cnt_r <= 8'd0;
    else if (wait_cnt_r != MAX_WAIT_C)        wait_cnt_r <= wait_cnt_r + 8'd1;
    else                                      wait_cnt_r <= wait_cnt_r;
  end
`endif

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed and random stimulus for dmem_arb against a
// behavioural model of arbitration, memory contents and responses.
module tb_dmem_arb;
  import riscv_pkg::*;

  localparam int MAX_WAIT = 8;
  localparam int AW       = $clog2(DMEM_SIZE);

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dmem_arb_if bus ();

  dmem_arb #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- memory environment ----------------
  logic [7:0] mem     [DMEM_SIZE];
  logic [7:0] ref_mem [DMEM_SIZE];

  function automatic logic [7:0] init_byte(input int k);
    return 8'((k * 37 + 11) & 255);
  endfunction

  function automatic int nbytes(input mem_op_e op);
    if (op == MEM_BYTE || op == MEM_BYTE_U) return 1;
    if (op == MEM_HALF || op == MEM_HALF_U) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] assemble(input mem_op_e op, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3);
    case (op)
      MEM_BYTE:   return {{24{b0[7]}}, b0};
      MEM_BYTE_U: return {24'd0, b0};
      MEM_HALF:   return {{16{b1[7]}}, b1, b0};
      MEM_HALF_U: return {16'd0, b1, b0};
      MEM_WORD:   return {b3, b2, b1, b0};
      default:    return 32'd0;
    endcase
  endfunction

  assign bus.m_rdata = assemble(bus.m_op, mem[AW'(bus.m_addr)], mem[AW'(bus.m_addr + 32'd1)],
                                mem[AW'(bus.m_addr + 32'd2)], mem[AW'(bus.m_addr + 32'd3)]);

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < DMEM_SIZE; k++) mem[k] <= init_byte(k);
    end else if (bus.m_wr_en) begin
      for (int k = 0; k < 4; k++)
        if (k < nbytes(bus.m_op) && (bus.m_addr + 32'(k)) < 32'(DMEM_SIZE))
          mem[AW'(bus.m_addr + 32'(k))] <= bus.m_wdata[8*k +: 8];
    end
  end

  // ---------------- reference model ----------------
  int          wait_cnt;
  int          last_g;
  logic [1:0]  exp_v;
  logic [1:0]  exp_err;
  logic [31:0] exp_hold [2];
  mem_op_e     ops [5] = '{MEM_BYTE, MEM_HALF, MEM_WORD, MEM_BYTE_U, MEM_HALF_U};

  function automatic logic model_fault(input logic [31:0] a, input mem_op_e op, input logic we);
    longint sz = longint'(nbytes(op));
    if (!(op inside {MEM_BYTE, MEM_HALF, MEM_WORD, MEM_BYTE_U, MEM_HALF_U})) return 1'b1;
    if (we && (op == MEM_BYTE_U || op == MEM_HALF_U)) return 1'b1;
    if ((longint'(a) % sz) != 0) return 1'b1;
    if (longint'(a) + sz > longint'(DMEM_SIZE)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    wait_cnt    = 0;
    last_g      = 0;
    exp_v       = 2'b00;
    exp_err     = 2'b00;
    exp_hold[0] = 32'd0;
    exp_hold[1] = 32'd0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input mem_op_e op,
                         input logic we, input logic [31:0] wd);
    bus.req_valid[i] = v;
    bus.req_addr[i]  = a;
    bus.req_op[i]    = op;
    bus.req_we[i]    = we;
    bus.req_wdata[i] = wd;
  endtask

  task automatic rand_req(input int i);
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = 32'(DMEM_SIZE - 4) + 32'($urandom_range(0, 7));
    else                           a = 32'($urandom_range(0, 127));
    set_req(i, $urandom_range(0, 3) != 0, a, ops[$urandom_range(0, 4)],
            1'($urandom_range(0, 1)), $urandom);
  endtask

  // One clock of checking: compare at negedge, then advance the model.
  task automatic tick(output int g);
    logic [1:0]  v;
    logic [1:0]  exp_rdy;
    logic [31:0] a;
    logic [31:0] wd;
    mem_op_e     op;
    logic        we;
    logic        flt;
    @(negedge clk);
    v = bus.req_valid;
    if (v == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
      g = (last_g == 0) ? 1 : 0;
`else
      g = (wait_cnt >= MAX_WAIT) ? 1 : 0;
`endif
    end else if (v[0]) g = 0;
    else if (v[1])     g = 1;
    else               g = -1;
    exp_rdy = 2'b00;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
    chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    chk("rsp_rdata0", 64'(bus.rsp_rdata[0]), 64'(exp_hold[0]));
    chk("rsp_rdata1", 64'(bus.rsp_rdata[1]), 64'(exp_hold[1]));
    exp_v   = exp_rdy;
    exp_err = 2'b00;
    if (g >= 0) begin
      a   = bus.req_addr[g];
      wd  = bus.req_wdata[g];
      op  = bus.req_op[g];
      we  = bus.req_we[g];
      flt = model_fault(a, op, we);
      chk("m_enables", 64'({bus.m_wr_en, bus.m_rd_en}), 64'({we & !flt, !we & !flt}));
      chk("m_addr_op", 64'({bus.m_op, bus.m_addr}), 64'({op, a}));
      chk("m_wdata", 64'(bus.m_wdata), 64'(wd));
      exp_err[g]  = flt;
      exp_hold[g] = (flt || we) ? 32'd0 :
                    assemble(op, ref_mem[AW'(a)], ref_mem[AW'(a + 32'd1)],
                             ref_mem[AW'(a + 32'd2)], ref_mem[AW'(a + 32'd3)]);
      if (we && !flt)
        for (int k = 0; k < nbytes(op); k++) ref_mem[AW'(a + 32'(k))] = wd[8*k +: 8];
      last_g = g;
    end else begin
      chk("m_idle", 64'({bus.m_op, bus.m_wr_en, bus.m_rd_en, bus.m_addr}), 64'd0);
    end
    if (!v[1] || g == 1)          wait_cnt = 0;
    else if (wait_cnt < MAX_WAIT) wait_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    int grants[$];
    int bad;

    // Reset state with both requesters already asking.
    reset    = 1'b1;
    mem_init = 1'b1;
    set_req(0, 1'b1, 32'h0, MEM_WORD, 1'b0, 32'd0);
    set_req(1, 1'b1, 32'h4, MEM_WORD, 1'b0, 32'd0);
    for (int k = 0; k < DMEM_SIZE; k++) ref_mem[k] = init_byte(k);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_m_en", 64'({bus.m_wr_en, bus.m_rd_en}), 64'd0);
    chk("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err}), 64'd0);
    chk("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    set_req(0, 1'b0, 32'h0, MEM_WORD, 1'b0, 32'd0);
    set_req(1, 1'b0, 32'h0, MEM_WORD, 1'b0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // DMA stores a word, then the core loads it back.
    set_req(1, 1'b1, 32'h10, MEM_WORD, 1'b1, 32'hDEADBEEF);
    tick(g);
    set_req(1, 1'b0, 32'h0, MEM_WORD, 1'b0, 32'd0);
    set_req(0, 1'b1, 32'h10, MEM_WORD, 1'b0, 32'd0);
    tick(g);
    set_req(0, 1'b0, 32'h0, MEM_WORD, 1'b0, 32'd0);
    chk("lw_after_dma_sw", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata[0]}),
        64'({2'b01, 2'b00, 32'hDEADBEEF}));
    tick(g);

    // Misaligned half load and out-of-range byte store both fault.
    set_req(0, 1'b1, 32'h21, MEM_HALF, 1'b0, 32'd0);
    tick(g);
    chk("lh_misaligned", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata[0]}),
        64'({2'b01, 2'b01, 32'd0}));
    set_req(0, 1'b1, 32'(DMEM_SIZE), MEM_BYTE, 1'b1, 32'hA5);
    tick(g);
    chk("sb_out_of_range", 64'({bus.rsp_valid, bus.rsp_err}), 64'({2'b01, 2'b01}));

    // Back-to-back store word then unsigned byte load.
    set_req(0, 1'b1, 32'h0, MEM_WORD, 1'b1, 32'h11223344);
    tick(g);
    set_req(0, 1'b1, 32'h3, MEM_BYTE_U, 1'b0, 32'd0);
    tick(g);
    chk("lbu_back_to_back", 64'({bus.rsp_valid, bus.rsp_rdata[0]}), 64'({2'b01, 32'h00000011}));
    set_req(0, 1'b0, 32'h0, MEM_WORD, 1'b0, 32'd0);
    tick(g);

    // Continuous contention.
    set_req(0, 1'b1, 32'h40, MEM_WORD, 1'b0, 32'd0);
    set_req(1, 1'b1, 32'h80, MEM_WORD, 1'b0, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick(g);
      grants.push_back(g);
    end
`ifdef DMEM_ARB_RR_EN
    for (int k = 1; k < 10; k++)
      chk("rr_alternate", 64'(grants[k] != grants[k-1]), 64'd1);
`else
    for (int k = 0; k < 10; k++)
      chk("starve_grant", 64'(grants[k]), 64'((k == 8) ? 1 : 0));
`endif

    // Build up DMA waiting, then reset while a response is pulsing.
    for (int k = 0; k < 6; k++) tick(g);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_kill_rsp", 64'({bus.rsp_valid, bus.rsp_err}), 64'd0);
    chk("rst_hold_ready", 64'({bus.req_ready, bus.m_wr_en, bus.m_rd_en}), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_no_pulse", 64'(bus.rsp_valid), 64'd0);
    set_req(0, 1'b0, 32'h40, MEM_WORD, 1'b0, 32'd0);
    set_req(1, 1'b0, 32'h80, MEM_WORD, 1'b0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    tick(g);
    set_req(0, 1'b1, 32'h40, MEM_WORD, 1'b0, 32'd0);
    set_req(1, 1'b1, 32'h80, MEM_WORD, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) tick(g);

    // Random traffic; unserved requesters keep their request stable.
    rand_req(0);
    rand_req(1);
    for (int n = 0; n < 400; n++) begin
      tick(g);
      for (int i = 0; i < 2; i++)
        if (!(bus.req_valid[i] && g != i)) rand_req(i);
    end
    set_req(0, 1'b0, 32'h0, MEM_WORD, 1'b0, 32'd0);
    set_req(1, 1'b0, 32'h0, MEM_WORD, 1'b0, 32'd0);
    tick(g);
    tick(g);

    // Memory image must match every legal store and nothing else.
    bad = 0;
    for (int k = 0; k < DMEM_SIZE; k++)
      if (mem[k] !== ref_mem[k]) bad++;
    chk("mem_image", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 8, meaning the number of consecutive cycles the DMA port may be denied before it is force-granted (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  2  request valid; index 0 = core MEM stage, index 1 = DMA/loader.
REQ-005 SHALL have port req_ready  output  2  request accepted this cycle, one-hot or zero.
REQ-006 SHALL have port req_addr  input  2xXLEN  byte address per requester.
REQ-007 SHALL have port req_wdata  input  2xXLEN  store data per requester.
REQ-008 SHALL have port req_we  input  2  1 = store, 0 = load.
REQ-009 SHALL have port req_op  input  2xmem_op_e  access width/sign per requester.
REQ-010 SHALL have port rsp_valid  output  2  one-cycle response pulse per requester.
REQ-011 SHALL have port rsp_rdata  output  2xXLEN  load data, registered.
REQ-012 SHALL have port rsp_err  output  2  access fault flag, qualified by rsp_valid.
REQ-013 SHALL have ports m_addr/m_wdata (output XLEN), m_wr_en/m_rd_en (output 1), m_op (output mem_op_e), m_rdata (input XLEN): the single data-memory port, combinational read, write on clk edge.

Function
REQ-014 SHALL complete a transfer on requester i when req_valid[i] && req_ready[i]; requesters hold valid and payload stable until ready.
REQ-015 SHALL assert req_ready[i] combinationally only for the granted valid requester; at most one bit set; zero when no request is valid.
REQ-016 SHALL, by default, grant index 0 when both are valid, except when the starvation counter equals MAX_WAIT, in which case index 1 is granted.
REQ-017 SHALL increment the 8-bit starvation counter each cycle req_valid[1] is high and not granted, saturating at MAX_WAIT, and clear it on an index-1 grant or when req_valid[1] is low.
REQ-018 SHALL flag a fault when: MEM_HALF/MEM_HALF_U with addr[0]=1; MEM_WORD with addr[1:0]!=0; addr+access size > DMEM_SIZE; or a store with MEM_BYTE_U/MEM_HALF_U.
REQ-019 SHALL drive m_* from the granted request in the acceptance cycle; m_rd_en = accept && !we && !fault; m_wr_en = accept && we && !fault; all m_* are zero when nothing is accepted.
REQ-020 SHALL pulse rsp_valid[i] exactly one cycle after acceptance (fixed 1-cycle latency), with rsp_rdata[i] = registered m_rdata for a good load and 0 for a store or fault, and rsp_err[i] = fault.
REQ-021 SHALL accept a new request in the same cycle that a previous response is pulsed (full throughput, one access per cycle).
REQ-022 SHALL hold rsp_rdata at its last value when rsp_valid is low; rsp_err is low whenever rsp_valid is low.

Reset
REQ-023 SHALL on reset clear rsp_valid, rsp_err, rsp_rdata, the starvation counter and the last-grant register to 0, asynchronously.
REQ-024 SHALL discard any response pending when reset asserts mid-operation; no rsp_valid pulse follows reset release.
REQ-025 SHALL hold req_ready at 0 and m_wr_en/m_rd_en at 0 while reset is high.

Configuration
REQ-026 SHALL, with DMEM_ARB_RR_EN defined, replace fixed priority with round-robin: on contention grant the index not granted last; the starvation counter is then not instantiated.
REQ-027 SHALL, without DMEM_ARB_RR_EN, use fixed priority plus starvation counter as in REQ-016/017.

Structure
REQ-028 SHALL take XLEN, DMEM_SIZE and mem_op_e from riscv_pkg, and SHALL add the typedef arb_idx_e (ARB_CORE=0, ARB_DMA=1) to riscv_pkg.
REQ-029 SHALL contain one sub-module, dmem_align_chk, computing the fault flag from addr, op and we (REQ-018).

Verification
REQ-030 Core LW addr 0x10 after a DMA SW of 0xDEADBEEF to 0x10 -> core rsp_valid one cycle after accept, rdata 0xDEADBEEF, err 0.
REQ-031 Both valid continuously, MAX_WAIT=8, fixed priority -> DMA granted on the 9th cycle, counter cleared, core granted next cycle.
REQ-032 Core LH addr 0x21 -> no m_rd_en, rsp_err=1, rdata 0; core SB to addr DMEM_SIZE -> err=1, memory unchanged.
REQ-033 DMEM_ARB_RR_EN defined, both valid for 6 cycles -> grants alternate 0,1,0,1,0,1.
REQ-034 Reset asserted the cycle after acceptance -> no rsp_valid pulse, counter 0, first post-reset grant to core.
REQ-035 Back-to-back core SW 0x11223344 to 0x0 then LBU 0x3 on consecutive cycles -> second rsp_rdata 0x00000011.
